// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StBusy  = 3'd2,
    StWb    = 3'd3,
    StDrain = 3'd4
  } state_e;

  // Register index of $rstatus and the exception codes written to it.
  localparam int unsigned STATUS_REG_DEF = 30;
  localparam int unsigned MUL_EXC_DEF    = 4;
  localparam int unsigned DIV_EXC_DEF    = 5;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Decode / multdiv / write-port signals seen by the sequencer.
interface multdiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  // Decode side
  logic             req_mul;
  logic             req_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       req_rd;
  logic             flush;
  logic             stall;
  logic             busy;
  // Multdiv unit side
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             md_ready;
  logic             md_exception;
  logic [WIDTH-1:0] md_result;
  // Register-file write port
  logic             wb_req;
  logic             wb_ack;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;

  modport slave (
    input  req_mul, req_div, op_a, op_b, req_rd, flush,
    input  md_ready, md_exception, md_result, wb_ack,
    output stall, busy, ctrl_mult, ctrl_div, md_a, md_b, wb_req, wb_rd, wb_data
  );

  modport master (
    output req_mul, req_div, op_a, op_b, req_rd, flush,
    output md_ready, md_exception, md_result, wb_ack,
    input  stall, busy, ctrl_mult, ctrl_div, md_a, md_b, wb_req, wb_rd, wb_data
  );

endinterface

// File: rtl/multdiv_sequencer_cycle_counter.sv
// Saturating cycle counter with synchronous clear and terminal-count flag.
module multdiv_sequencer_cycle_counter #(
  parameter int unsigned CNT_BITS   = 6,
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_BITS-1:0] cnt_q;

  assign tc_o = (cnt_q == CNT_BITS'(MAX_CYCLES - 1));

  // Count while enabled; stick at the terminal value instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mul/div ops to the shared multicycle unit, stalls decode meanwhile,
// and arbitrates the result (or an exception code) onto the regfile write port.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_BITS   = 6,
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned STATUS_REG = STATUS_REG_DEF,
  parameter int unsigned MUL_EXC    = MUL_EXC_DEF,
  parameter int unsigned DIV_EXC    = DIV_EXC_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  multdiv_sequencer_if.slave  bus
);

  state_e           state_q;
  logic             is_mul_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] md_a_q;
  logic [WIDTH-1:0] md_b_q;
  logic             ctrl_mult_q;
  logic             ctrl_div_q;
  logic             wb_req_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             req_any;
  logic             tc;

  assign req_any = bus.req_mul | bus.req_div;

  // Timeout counter runs while the unit may still be working on an op.
  multdiv_sequencer_cycle_counter #(
    .CNT_BITS  (CNT_BITS),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_cycle_counter (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state_q == StIssue),
    .en_i ((state_q == StBusy) || (state_q == StDrain)),
    .tc_o (tc)
  );

  // Main FSM with registered start pulses and writeback outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      is_mul_q    <= 1'b0;
      rd_q        <= '0;
      md_a_q      <= '0;
      md_b_q      <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_req_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_any && !bus.flush) begin
            is_mul_q    <= bus.req_mul;
            rd_q        <= bus.req_rd;
            md_a_q      <= bus.op_a;
            md_b_q      <= bus.op_b;
            ctrl_mult_q <= bus.req_mul;
            ctrl_div_q  <= ~bus.req_mul;
            state_q     <= StIssue;
          end
        end
        // The start pulse is already out, so a flush here must still drain.
        StIssue: state_q <= bus.flush ? StDrain : StBusy;
        StBusy: begin
          if (bus.flush) begin
            // A result arriving with the flush means the unit is already idle.
            state_q <= bus.md_ready ? StIdle : StDrain;
          end else if (bus.md_ready) begin
            wb_req_q <= 1'b1;
            if (bus.md_exception) begin
              wb_rd_q   <= 5'(STATUS_REG);
              wb_data_q <= is_mul_q ? WIDTH'(MUL_EXC) : WIDTH'(DIV_EXC);
            end else begin
              wb_rd_q   <= rd_q;
              wb_data_q <= bus.md_result;
            end
            state_q <= StWb;
          end else if (tc) begin
            wb_req_q  <= 1'b1;
            wb_rd_q   <= 5'(STATUS_REG);
            wb_data_q <= WIDTH'(DIV_EXC);
            state_q   <= StWb;
          end
        end
        StWb: begin
          if (bus.wb_ack) begin
            wb_req_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StDrain: begin
          if (bus.md_ready || tc) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall follows the request combinationally so decode freezes on the request cycle.
  always_comb begin
    bus.stall = 1'b0;
    unique case (state_q)
      StIdle:          bus.stall = req_any & ~bus.flush;
      StIssue, StBusy: bus.stall = 1'b1;
      StWb:            bus.stall = ~bus.wb_ack;
      StDrain:         bus.stall = req_any & ~bus.flush;
      default:         bus.stall = 1'b0;
    endcase
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.ctrl_mult = ctrl_mult_q;
  assign bus.ctrl_div  = ctrl_div_q;
  assign bus.md_a      = md_a_q;
  assign bus.md_b      = md_b_q;
  assign bus.wb_req    = wb_req_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  multdiv_sequencer_if #(.WIDTH(32)) bus ();

  multdiv_sequencer #(
    .WIDTH     (32),
    .CNT_BITS  (6),
    .MAX_CYCLES(40),
    .STATUS_REG(30),
    .MUL_EXC   (4),
    .DIV_EXC   (5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Observations collected by do_op for the calling test to judge.
  bit          got_wb;
  logic [4:0]  o_rd;
  logic [31:0] o_data;
  int          o_mp, o_dp, o_wbcyc;
  bit          o_stall_ok, o_hold_ok;
  logic        o_ack_stall, o_busy_after;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from IDLE; md_ready is pulsed in cycle lat after ISSUE (lat<0: never).
  task automatic do_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input bit exc,
                       input logic [31:0] res, input int ack_delay);
    got_wb = 0; o_mp = 0; o_dp = 0; o_wbcyc = -1; o_hold_ok = 1;
    bus.req_mul = mul; bus.req_div = !mul; bus.op_a = a; bus.op_b = b; bus.req_rd = rd;
    #1;
    o_stall_ok = bus.stall;
    step();
    bus.req_mul = 0; bus.req_div = 0;
    for (int k = 0; k < 100 && !got_wb; k++) begin
      o_mp += int'(bus.ctrl_mult);
      o_dp += int'(bus.ctrl_div);
      if (bus.wb_req) begin
        got_wb  = 1;
        o_wbcyc = k;
      end else begin
        if (!bus.stall) o_stall_ok = 0;
        bus.md_ready     = (k == lat);
        bus.md_exception = exc;
        bus.md_result    = res;
        step();
      end
    end
    bus.md_ready = 0; bus.md_exception = 0;
    o_rd = bus.wb_rd; o_data = bus.wb_data;
    for (int i = 0; i < ack_delay; i++) begin
      bus.flush = 1;  // flush while waiting in WB must not cancel the write
      step();
      if (!bus.wb_req || bus.wb_rd !== o_rd || bus.wb_data !== o_data) o_hold_ok = 0;
    end
    bus.flush  = 0;
    bus.wb_ack = 1;
    #1;
    o_ack_stall = bus.stall;
    step();
    bus.wb_ack   = 0;
    o_busy_after = bus.busy;
  endtask

  task automatic test_reset();
    n_total++;
    if ({bus.ctrl_mult, bus.ctrl_div, bus.wb_req, bus.stall, bus.busy,
         bus.md_a, bus.md_b, bus.wb_rd, bus.wb_data} !== '0)
      $display("FAIL reset_outputs: got wb_rd=%0d wb_data=%0h busy=%b wb_req=%b required all 0",
               bus.wb_rd, bus.wb_data, bus.busy, bus.wb_req);
    else n_pass++;
  endtask

  task automatic test_mul();
    do_op(1, 32'd6, 32'd7, 5'd3, 32, 0, 32'd42, 0);
    n_total++;
    if (o_mp !== 1 || o_dp !== 0) $display("FAIL mul_pulse: mult=%0d div=%0d required 1/0", o_mp, o_dp);
    else n_pass++;
    n_total++;
    if (o_stall_ok !== 1) $display("FAIL mul_stall: stall dropped before WB, required 1");
    else n_pass++;
    n_total++;
    if (!got_wb || o_rd !== 5'd3 || o_data !== 32'd42)
      $display("FAIL mul_wb: got=%0b rd=%0d data=%0d required rd=3 data=42", got_wb, o_rd, o_data);
    else n_pass++;
    n_total++;
    if (o_wbcyc !== 33) $display("FAIL mul_latency: wb at cycle %0d required 33", o_wbcyc);
    else n_pass++;
    n_total++;
    if (o_ack_stall !== 1'b0 || o_busy_after !== 1'b0)
      $display("FAIL mul_ack: stall=%b busy=%b required 0/0", o_ack_stall, o_busy_after);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    do_op(0, 32'd5, 32'd0, 5'd9, 10, 1, 32'hdead_beef, 0);
    n_total++;
    if (o_dp !== 1 || o_mp !== 0) $display("FAIL div_pulse: mult=%0d div=%0d required 0/1", o_mp, o_dp);
    else n_pass++;
    n_total++;
    if (!got_wb || o_rd !== 5'd30 || o_data !== 32'd5)
      $display("FAIL div_zero_wb: rd=%0d data=%0h required rd=30 data=5", o_rd, o_data);
    else n_pass++;
  endtask

  task automatic test_mul_overflow();
    do_op(1, 32'h4000_0000, 32'd4, 5'd12, 20, 1, 32'd0, 0);
    n_total++;
    if (!got_wb || o_rd !== 5'd30 || o_data !== 32'd4)
      $display("FAIL mul_ovf_wb: rd=%0d data=%0h required rd=30 data=4", o_rd, o_data);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_op(1, 32'd1, 32'd2, 5'd4, -1, 0, 32'd0, 0);
    n_total++;
    if (!got_wb || o_rd !== 5'd30 || o_data !== 32'd5)
      $display("FAIL timeout_wb: rd=%0d data=%0h required rd=30 data=5", o_rd, o_data);
    else n_pass++;
    n_total++;
    if (o_wbcyc !== 41) $display("FAIL timeout_cycle: wb at cycle %0d required 41", o_wbcyc);
    else n_pass++;
    n_total++;
    if (o_busy_after !== 1'b0) $display("FAIL timeout_busy: busy=%b required 0", o_busy_after);
    else n_pass++;
  endtask

  task automatic test_ack_hold();
    do_op(0, 32'd100, 32'd7, 5'd8, 5, 0, 32'd14, 3);
    n_total++;
    if (o_hold_ok !== 1 || o_rd !== 5'd8 || o_data !== 32'd14)
      $display("FAIL ack_hold: hold_ok=%0b rd=%0d data=%0d required 1/8/14", o_hold_ok, o_rd, o_data);
    else n_pass++;
  endtask

  task automatic test_flush_drain();
    int early = 0, bad_wb = 0;
    bit got = 0;
    bus.req_mul = 1; bus.op_a = 32'd2; bus.op_b = 32'd3; bus.req_rd = 5'd6;
    step();
    bus.req_mul = 0;
    for (int k = 0; k <= 32; k++) begin
      if (k >= 1 && bus.ctrl_mult) early++;
      if (bus.wb_req) bad_wb++;
      bus.flush = (k == 10);
      if (k == 11) begin
        #1;
        n_total++;
        if (bus.stall !== 1'b0) $display("FAIL drain_stall_idle: stall=%b required 0", bus.stall);
        else n_pass++;
        bus.req_mul = 1; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.req_rd = 5'd7;
        #1;
        n_total++;
        if (bus.stall !== 1'b1 || bus.busy !== 1'b1)
          $display("FAIL drain_stall_req: stall=%b busy=%b required 1/1", bus.stall, bus.busy);
        else n_pass++;
      end
      bus.md_ready  = (k == 32);
      bus.md_result = 32'h1234;
      step();
    end
    bus.md_ready = 0; bus.flush = 0;
    if (bus.wb_req) bad_wb++;
    if (bus.ctrl_mult) early++;
    step();  // new request seen in IDLE -> ISSUE
    bus.req_mul = 0;
    n_total++;
    if (early !== 0 || bad_wb !== 0 || bus.ctrl_mult !== 1'b1 || bus.md_a !== 32'd9)
      $display("FAIL drain_reissue: early=%0d old_wb=%0d ctrl_mult=%b md_a=%0d required 0/0/1/9",
               early, bad_wb, bus.ctrl_mult, bus.md_a);
    else n_pass++;
    for (int k = 0; k < 60 && !got; k++) begin
      if (bus.wb_req) got = 1;
      else begin
        bus.md_ready = (k == 4); bus.md_result = 32'd81;
        step();
      end
    end
    bus.md_ready = 0;
    n_total++;
    if (!got || bus.wb_rd !== 5'd7 || bus.wb_data !== 32'd81)
      $display("FAIL drain_new_wb: got=%0b rd=%0d data=%0d required rd=7 data=81",
               got, bus.wb_rd, bus.wb_data);
    else n_pass++;
    bus.wb_ack = 1;
    step();
    bus.wb_ack = 0;
  endtask

  task automatic test_flush_with_ready();
    bus.req_div = 1; bus.op_a = 32'd8; bus.op_b = 32'd2; bus.req_rd = 5'd5;
    step();
    bus.req_div = 0;
    for (int k = 0; k < 5; k++) step();
    bus.flush = 1; bus.md_ready = 1; bus.md_result = 32'd4;
    step();
    bus.flush = 0; bus.md_ready = 0;
    n_total++;
    if (bus.busy !== 1'b0 || bus.wb_req !== 1'b0)
      $display("FAIL flush_ready: busy=%b wb_req=%b required 0/0", bus.busy, bus.wb_req);
    else n_pass++;
  endtask

  task automatic test_reset_busy();
    int stray = 0;
    bus.req_mul = 1; bus.op_a = 32'd11; bus.op_b = 32'd13; bus.req_rd = 5'd2;
    step();
    bus.req_mul = 0;
    for (int k = 0; k < 6; k++) step();
    #2 rst = 1;
    #1;
    n_total++;
    if ({bus.ctrl_mult, bus.ctrl_div, bus.wb_req, bus.stall, bus.busy,
         bus.md_a, bus.md_b, bus.wb_rd, bus.wb_data} !== '0)
      $display("FAIL reset_midop: busy=%b md_a=%0d md_b=%0d required all 0",
               bus.busy, bus.md_a, bus.md_b);
    else n_pass++;
    step();
    #2 rst = 0;
    step();
    bus.md_ready = 1; bus.md_result = 32'd143;
    step();
    bus.md_ready = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.wb_req || bus.busy) stray++;
      step();
    end
    n_total++;
    if (stray !== 0) $display("FAIL reset_stray_ready: %0d cycles active, required 0", stray);
    else n_pass++;
  endtask

  initial begin
    bus.req_mul = 0; bus.req_div = 0; bus.op_a = '0; bus.op_b = '0; bus.req_rd = '0;
    bus.flush = 0; bus.md_ready = 0; bus.md_exception = 0; bus.md_result = '0; bus.wb_ack = 0;
    #12;
    test_reset();
    #5 rst = 0;
    step();
    test_mul();
    test_div_zero();
    test_mul_overflow();
    test_timeout();
    test_ack_hold();
    test_flush_drain();
    test_flush_with_ready();
    test_reset_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
